// File: rtl/operand_entry.sv
// operand_entry
//   Four-digit BCD operand editor. The user moves a cursor over digits d3..d0
//   and increments or decrements the selected digit. Two commits capture the
//   first operand (A) and then the second operand (B), each converted to
//   binary. The pair is then offered downstream with a valid/ready handshake.
//
// State table:
//   ENTER_A (0) | editing the first operand; enter commits it to operand_a
//   ENTER_B (1) | editing the second operand; enter commits it to operand_b
//   DONE    (2) | pair offered on out_valid; buttons ignored until out_ready
//   (3)         | illegal encoding, recovers to ENTER_A on the next clock
//
// Ports:
//   clk                  system clock, all updates on the rising edge
//   rst                  synchronous active-high reset
//   btn_up/down          one-cycle pulses, +1/-1 on the selected digit (mod 10)
//   btn_left/right       one-cycle pulses, cursor toward MSD / toward LSD
//   btn_enter            one-cycle pulse, commits the current entry
//   out_ready            downstream accepts the operand pair
//   digits               {d3,d2,d1,d0} BCD digits being edited
//   cursor               selected digit index, 0 = d0
//   phase                state code (see table)
//   operand_a/operand_b  committed binary operands (0..9999)
//   out_valid            operand pair available (DONE only)

module operand_entry #(
    parameter bit CURSOR_WRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_enter,
    input  logic        out_ready,
    output logic [15:0] digits,
    output logic [1:0]  cursor,
    output logic [1:0]  phase,
    output logic [13:0] operand_a,
    output logic [13:0] operand_b,
    output logic        out_valid
);

    localparam logic [1:0] ST_ENTER_A = 2'd0;
    localparam logic [1:0] ST_ENTER_B = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0]  state_q;
    logic [1:0]  state_nxt;
    logic [3:0]  dig_q [4];
    logic [1:0]  cursor_q;
    logic [13:0] operand_a_q;
    logic [13:0] operand_b_q;
    logic        out_valid_q;

    logic        editing;
    logic        act_enter;
    logic        act_up;
    logic        act_down;
    logic        act_left;
    logic        act_right;

    logic [3:0]  sel_digit;
    logic [3:0]  sel_inc;
    logic [3:0]  sel_dec;
    logic [1:0]  cursor_left;
    logic [1:0]  cursor_right;
    logic [13:0] bcd_value;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ENTER_A;
        end else begin
            state_q <= state_nxt;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        state_nxt = ST_ENTER_A;
        case (state_q)
            ST_ENTER_A: state_nxt = act_enter ? ST_ENTER_B : ST_ENTER_A;
            ST_ENTER_B: state_nxt = act_enter ? ST_DONE    : ST_ENTER_B;
            ST_DONE:    state_nxt = (out_valid_q && out_ready) ? ST_ENTER_A : ST_DONE;
            default:    state_nxt = ST_ENTER_A;
        endcase
    end

    // --------------------------------------------------------- action decode
    // Exactly one action per cycle: enter > up > down > left > right.
    always_comb begin
        editing   = (state_q == ST_ENTER_A) || (state_q == ST_ENTER_B);
        act_enter = editing && btn_enter;
        act_up    = editing && !btn_enter && btn_up;
        act_down  = editing && !btn_enter && !btn_up && btn_down;
        act_left  = editing && !btn_enter && !btn_up && !btn_down && btn_left;
        act_right = editing && !btn_enter && !btn_up && !btn_down && !btn_left && btn_right;
    end

    // ------------------------------------------------------------- datapath
    always_comb begin
        sel_digit = dig_q[cursor_q];
        // >= 9 rather than == 9 so a corrupted digit still returns to range
        sel_inc   = (sel_digit >= 4'd9) ? 4'd0 : sel_digit + 4'd1;
        sel_dec   = (sel_digit == 4'd0 || sel_digit > 4'd9) ? 4'd9 : sel_digit - 4'd1;

        if (cursor_q == 2'd3) begin
            cursor_left = CURSOR_WRAP ? 2'd0 : 2'd3;
        end else begin
            cursor_left = cursor_q + 2'd1;
        end

        if (cursor_q == 2'd0) begin
            cursor_right = CURSOR_WRAP ? 2'd3 : 2'd0;
        end else begin
            cursor_right = cursor_q - 2'd1;
        end

        bcd_value = ({10'd0, dig_q[3]} * 14'd1000)
                  + ({10'd0, dig_q[2]} * 14'd100)
                  + ({10'd0, dig_q[1]} * 14'd10)
                  +  {10'd0, dig_q[0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                dig_q[i] <= 4'd0;
            end
            cursor_q    <= 2'd0;
            operand_a_q <= 14'd0;
            operand_b_q <= 14'd0;
        end else if (act_enter) begin
            for (int i = 0; i < 4; i++) begin
                dig_q[i] <= 4'd0;
            end
            cursor_q <= 2'd0;
            if (state_q == ST_ENTER_A) begin
                operand_a_q <= bcd_value;
            end else begin
                operand_b_q <= bcd_value;
            end
        end else if (act_up) begin
            dig_q[cursor_q] <= sel_inc;
        end else if (act_down) begin
            dig_q[cursor_q] <= sel_dec;
        end else if (act_left) begin
            cursor_q <= cursor_left;
        end else if (act_right) begin
            cursor_q <= cursor_right;
        end
    end

    // out_valid is a flop tracking entry into DONE, so it rises together with
    // phase=DONE the cycle after the ENTER_B commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_nxt == ST_DONE);
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        digits    = {dig_q[3], dig_q[2], dig_q[1], dig_q[0]};
        cursor    = cursor_q;
        phase     = state_q;
        operand_a = operand_a_q;
        operand_b = operand_b_q;
        out_valid = out_valid_q;
    end

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry. Two instances share all inputs: one with
// cursor wrap enabled (w_*) and one with saturation (s_*). Inputs change on
// the falling edge, outputs are sampled on the falling edge.

module tb_operand_entry;

    // btn vector bit order: {enter, up, down, left, right}
    localparam logic [4:0] B_ENTER = 5'b10000;
    localparam logic [4:0] B_UP    = 5'b01000;
    localparam logic [4:0] B_DOWN  = 5'b00100;
    localparam logic [4:0] B_LEFT  = 5'b00010;
    localparam logic [4:0] B_RIGHT = 5'b00001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn = 5'b0;
    logic       out_ready = 1'b0;

    logic [15:0] w_digits, s_digits;
    logic [1:0]  w_cursor, s_cursor;
    logic [1:0]  w_phase, s_phase;
    logic [13:0] w_operand_a, s_operand_a;
    logic [13:0] w_operand_b, s_operand_b;
    logic        w_out_valid, s_out_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    operand_entry #(.CURSOR_WRAP(1'b1)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn[3]),
        .btn_down  (btn[2]),
        .btn_left  (btn[1]),
        .btn_right (btn[0]),
        .btn_enter (btn[4]),
        .out_ready (out_ready),
        .digits    (w_digits),
        .cursor    (w_cursor),
        .phase     (w_phase),
        .operand_a (w_operand_a),
        .operand_b (w_operand_b),
        .out_valid (w_out_valid)
    );

    operand_entry #(.CURSOR_WRAP(1'b0)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn[3]),
        .btn_down  (btn[2]),
        .btn_left  (btn[1]),
        .btn_right (btn[0]),
        .btn_enter (btn[4]),
        .out_ready (out_ready),
        .digits    (s_digits),
        .cursor    (s_cursor),
        .phase     (s_phase),
        .operand_a (s_operand_a),
        .operand_b (s_operand_b),
        .out_valid (s_out_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the last
    // sampling rising edge.
    task automatic hold(input logic [4:0] b, input int n);
        btn = b;
        repeat (n) @(negedge clk);
        btn = 5'b0;
    endtask

    task automatic pulse(input logic [4:0] b);
        hold(b, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn = 5'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        // reset with buttons active: reset must win
        rst = 1'b1;
        hold(B_UP | B_LEFT, 2);
        rst = 1'b0;
        chk("rst_digits", w_digits, 16'h0000);
        chk("rst_cursor", w_cursor, 2'd0);
        chk("rst_phase", w_phase, 2'd0);
        chk("rst_opa", w_operand_a, 14'd0);
        chk("rst_valid", w_out_valid, 1'b0);

        // up x3, left, up held 7 cycles, enter
        repeat (3) pulse(B_UP);
        chk("up3_digits", w_digits, 16'h0003);
        pulse(B_LEFT);
        chk("left_cursor", w_cursor, 2'd1);
        hold(B_UP, 7);
        chk("up7_digits", w_digits, 16'h0073);
        pulse(B_ENTER);
        chk("commit_a_opa", w_operand_a, 14'd73);
        chk("commit_a_digits", w_digits, 16'h0000);
        chk("commit_a_cursor", w_cursor, 2'd0);
        chk("commit_a_phase", w_phase, 2'd1);

        // ENTER_B: down from 0 wraps to 9, left x4 wraps cursor, commit
        pulse(B_DOWN);
        chk("down_wrap", w_digits, 16'h0009);
        hold(B_LEFT, 4);
        chk("left4_wrap", w_cursor, 2'd0);
        chk("b_valid_low", w_out_valid, 1'b0);
        pulse(B_ENTER);
        chk("commit_b_opb", w_operand_b, 14'd9);
        chk("commit_b_phase", w_phase, 2'd2);
        chk("commit_b_valid", w_out_valid, 1'b1);

        // DONE: buttons ignored while out_ready low
        for (int i = 0; i < 5; i++) begin
            pulse((i % 2 == 0) ? B_UP : B_ENTER);
        end
        chk("done_opa", w_operand_a, 14'd73);
        chk("done_opb", w_operand_b, 14'd9);
        chk("done_valid", w_out_valid, 1'b1);
        chk("done_digits", w_digits, 16'h0000);
        chk("done_phase", w_phase, 2'd2);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("handshake_phase", w_phase, 2'd0);
        chk("handshake_valid", w_out_valid, 1'b0);
        chk("handshake_opa", w_operand_a, 14'd73);
        chk("handshake_opb", w_operand_b, 14'd9);

        // same-cycle priority
        pulse(B_UP | B_LEFT);
        chk("prio_up_left_dig", w_digits, 16'h0001);
        chk("prio_up_left_cur", w_cursor, 2'd0);
        pulse(B_ENTER | B_UP);
        chk("prio_enter_opa", w_operand_a, 14'd1);
        chk("prio_enter_phase", w_phase, 2'd1);
        chk("prio_enter_dig", w_digits, 16'h0000);

        // up wraps 9 -> 0
        hold(B_UP, 9);
        chk("up9", w_digits, 16'h0009);
        pulse(B_UP);
        chk("up_wrap", w_digits, 16'h0000);
        pulse(B_RIGHT);
        chk("right_wrap", w_cursor, 2'd3);
        pulse(B_DOWN | B_LEFT | B_RIGHT);
        chk("prio_down_dig", w_digits, 16'h9000);
        chk("prio_down_cur", w_cursor, 2'd3);
        pulse(B_LEFT | B_RIGHT);
        chk("prio_left_cur", w_cursor, 2'd0);

        // mid-entry reset, then first pulse after reset
        do_reset();
        pulse(B_ENTER);
        chk("zero_commit_phase", w_phase, 2'd1);
        hold(B_UP, 4);
        pulse(B_LEFT);
        hold(B_UP, 3);
        pulse(B_LEFT);
        hold(B_UP, 2);
        pulse(B_LEFT);
        hold(B_UP, 1);
        chk("build_1234", w_digits, 16'h1234);
        chk("build_cursor", w_cursor, 2'd3);
        rst = 1'b1;
        btn = B_UP | B_ENTER;
        @(negedge clk);
        chk("mid_rst_digits", w_digits, 16'h0000);
        chk("mid_rst_cursor", w_cursor, 2'd0);
        chk("mid_rst_phase", w_phase, 2'd0);
        chk("mid_rst_valid", w_out_valid, 1'b0);
        rst = 1'b0;
        btn = B_UP;
        @(negedge clk);
        btn = 5'b0;
        chk("first_after_rst", w_digits, 16'h0001);

        // saturating cursor instance
        do_reset();
        pulse(B_RIGHT);
        chk("sat_right", s_cursor, 2'd0);
        hold(B_LEFT, 5);
        chk("sat_left5", s_cursor, 2'd3);
        pulse(B_DOWN);
        for (int i = 0; i < 3; i++) begin
            pulse(B_RIGHT);
            pulse(B_DOWN);
        end
        chk("sat_9999_dig", s_digits, 16'h9999);
        chk("sat_9999_cur", s_cursor, 2'd0);
        pulse(B_ENTER);
        chk("sat_9999_opa", s_operand_a, 14'h270F);
        chk("sat_9999_phase", s_phase, 2'd1);
        pulse(B_RIGHT);
        chk("sat_right_again", s_cursor, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 Parameter: CURSOR_WRAP, default 1, meaning 1 = cursor wraps past digit 3/0 and 0 = cursor saturates at the ends.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 btn_up  input  1  one-cycle pulse from the upstream edge detector; increments the selected digit.
REQ-005 btn_down  input  1  one-cycle pulse; decrements the selected digit.
REQ-006 btn_left  input  1  one-cycle pulse; moves the cursor toward the most significant digit (cursor+1).
REQ-007 btn_right  input  1  one-cycle pulse; moves the cursor toward the least significant digit (cursor-1).
REQ-008 btn_enter  input  1  one-cycle pulse; commits the current entry.
REQ-009 out_ready  input  1  downstream accepts the operand pair.
REQ-010 digits  output  16  BCD digits {d3,d2,d1,d0} being edited, for display.
REQ-011 cursor  output  2  index of the selected digit; 0 = d0 (least significant).
REQ-012 phase  output  2  state code: 0 = ENTER_A, 1 = ENTER_B, 2 = DONE.
REQ-013 operand_a  output  14  binary value of the committed first operand.
REQ-014 operand_b  output  14  binary value of the committed second operand.
REQ-015 out_valid  output  1  operand pair is available.

Function
REQ-016 The FSM states shall be ENTER_A, ENTER_B and DONE; encodings 3 and above shall be illegal and shall recover to ENTER_A on the next clock.
REQ-017 In ENTER_A, btn_enter shall load operand_a with d3*1000+d2*100+d1*10+d0, clear the digits to 0, set the cursor to 0 and move the FSM to ENTER_B.
REQ-018 In ENTER_B, btn_enter shall load operand_b with the same conversion, clear the digits, set the cursor to 0 and move the FSM to DONE.
REQ-019 out_valid shall be 1 only in DONE, registered, and asserted starting the cycle after the ENTER_B commit.
REQ-020 In DONE, out_valid && out_ready in a cycle shall move the FSM to ENTER_A at the next edge; operand_a and operand_b shall hold their values.
REQ-021 In DONE, all btn_* inputs shall be ignored; operand_a, operand_b, digits and cursor shall stay stable while out_valid=1.
REQ-022 btn_up shall make the selected digit 9 go to 0 and any other digit v go to v+1; no carry into adjacent digits.
REQ-023 btn_down shall make the selected digit 0 go to 9 and any other digit v go to v-1; no borrow from adjacent digits.
REQ-024 With CURSOR_WRAP=1, btn_left at cursor 3 shall go to 0 and btn_right at cursor 0 shall go to 3.
REQ-025 With CURSOR_WRAP=0, btn_left at cursor 3 and btn_right at cursor 0 shall leave the cursor unchanged.
REQ-026 When several pulses occur in one cycle, exactly one action shall occur, in priority order enter > up > down > left > right; all lower-priority pulses in that cycle shall be dropped.
REQ-027 Held inputs (level high for N cycles) shall act once per cycle; the block shall not detect edges itself.
REQ-028 Each digit register shall only ever hold 0-9; operand values shall be within 0-9999.
REQ-029 The BCD-to-binary conversion shall be combinational from the digit registers and registered only on commit.
REQ-030 Edits shall be visible on digits and cursor one cycle after the pulse.

Reset
REQ-031 rst=1 at a clock edge shall set the FSM to ENTER_A and set digits, cursor, operand_a and operand_b to 0, and out_valid to 0.
REQ-032 rst shall override all btn_* inputs and out_ready in the same cycle, including reset asserted mid-entry or while in DONE.
REQ-033 The first pulse accepted after reset shall be the one sampled in the first cycle with rst=0.

Verification
REQ-034 Reset, then up x3, left, up x7, enter: operand_a=73, digits=0, cursor=0, phase=1.
REQ-035 From ENTER_B with digits 0: down at cursor 0 gives d0=9; left x4 with CURSOR_WRAP=1 gives cursor=0; enter gives operand_b=9, out_valid=1 next cycle.
REQ-036 In DONE with out_ready=0 for 5 cycles while pulsing up/enter: operands and out_valid=1 unchanged; raise out_ready: phase=0 and out_valid=0 next cycle.
REQ-037 Same-cycle pulses: up+left in one cycle gives only d0+1 with cursor unchanged; enter+up gives a commit only, with no digit change before the clear.
REQ-038 With CURSOR_WRAP=0: right at cursor 0 leaves cursor=0; left x5 gives cursor=3; enter 9999 gives operand=9999 (14'h270F).
REQ-039 Mid-entry (digits=0x1234, phase=1) assert rst for 1 cycle: all outputs 0 and phase=0 on the following cycle.
